// File: rtl/bench_resp_misr.sv
// ============================================================================
// bench_resp_misr
// ----------------------------------------------------------------------------
// Response compactor for the sequential benchmark circuits. It folds a fixed
// window of DATA_W-bit circuit-under-test responses into a SIG_W-bit
// multiple-input signature register. It then reports whether the final
// signature equals a supplied golden value.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-low reset
//   start       in   request a new compaction window (IDLE/DONE only)
//   abort       in   cancel a window in progress, or leave DONE
//   resp_valid  in   resp_in holds a sample to compact this cycle
//   resp_in     in   circuit-under-test response, DATA_W bits
//   golden_sig  in   expected signature, sampled on the DONE-entry edge
//   busy        out  window in progress (SEED or RUN)
//   done        out  window complete (DONE)
//   match       out  final signature == golden_sig, only while done
//   sig_out     out  current signature register
//   sample_cnt  out  samples accepted in the current or last window
// ============================================================================
module bench_resp_misr #(
    parameter int               DATA_W = 11,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = 16'h1021,
    parameter logic [SIG_W-1:0] SEED   = 16'hFFFF,
    parameter int               WINDOW = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        resp_valid,
    input  logic [DATA_W-1:0]           resp_in,
    input  logic [SIG_W-1:0]            golden_sig,
    output logic                        busy,
    output logic                        done,
    output logic                        match,
    output logic [SIG_W-1:0]            sig_out,
    output logic [$clog2(WINDOW):0]     sample_cnt
);

    localparam int CNT_W = $clog2(WINDOW) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEED,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SIG_W-1:0]   sig_q,   sig_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               match_q, match_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic [SIG_W-1:0]   sig_next;

    // One MISR step: Galois shift with POLY feedback, then fold in the sample.
    always_comb begin
        sig_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0)
                   ^ SIG_W'(resp_in);
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        match_d = match_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEED;
                end
            end

            S_SEED: begin
                // Inputs are ignored here; samples in this cycle are dropped.
                state_d = S_RUN;
            end

            S_RUN: begin
                if (abort) begin
                    // Partial signature and count stay visible after abort.
                    state_d = S_IDLE;
                end else if (resp_valid) begin
                    sig_d = sig_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WINDOW - 1)) begin
                        state_d = S_DONE;
                        match_d = (sig_next == golden_sig);
                    end
                end
            end

            S_DONE: begin
                if (start) begin
                    state_d = S_SEED;
                end else if (abort) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Seed is loaded on the edge entering SEED so the SEED cycle already
        // shows the fresh window (signature = SEED, count = 0, no match).
        if (state_d == S_SEED) begin
            sig_d   = SEED;
            cnt_d   = '0;
        end
        if (state_d != S_DONE) begin
            match_d = 1'b0;
        end

        busy_d = (state_d == S_SEED) || (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign match      = match_q;
    assign sig_out    = sig_q;
    assign sample_cnt = cnt_q;

endmodule

// File: doc/bench_resp_misr.md
# bench_resp_misr

Downstream response compactor for the generic sequential benchmark circuits. It consumes the circuit-under-test's 11-bit output stream and folds a fixed window of samples into a 16-bit multiple-input signature register (MISR). It then flags whether the final signature matches a supplied golden value. It sits between the benchmark's `out` bus and the trojan-detection comparison logic, so one signature replaces thousands of cycle-by-cycle output checks.

## Interface
Parameters:
- `DATA_W`, 11: width of the response input. Must be ≤ `SIG_W`.
- `SIG_W`, 16: signature width.
- `POLY`, 16'h1021: feedback taps (x^16+x^12+x^5+1).
- `SEED`, 16'hFFFF: value loaded into the signature at window start.
- `WINDOW`, 256: number of accepted samples per signature. Must be ≥ 1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request a new compaction window.
- `abort`, in, 1: cancel a window in progress.
- `resp_valid`, in, 1: `resp_in` is a sample to compact this cycle.
- `resp_in`, in, `DATA_W`: circuit-under-test response.
- `golden_sig`, in, `SIG_W`: expected signature. Sampled on the DONE-entry edge.
- `busy`, out, 1: high in SEED or RUN.
- `done`, out, 1: high in DONE.
- `match`, out, 1: final signature equals `golden_sig`. Valid only while `done` is high, otherwise 0.
- `sig_out`, out, `SIG_W`: current signature register.
- `sample_cnt`, out, $clog2(WINDOW)+1: number of samples accepted in the current or last window.

## Operation
- States: IDLE, SEED, RUN, DONE. All state and outputs are registered.
- Reset: state IDLE, `sig_out`=0, `sample_cnt`=0, `busy`=0, `done`=0, `match`=0.
- IDLE:
  - `start`=1 → SEED.
  - `abort` has no effect.
- SEED (exactly 1 cycle):
  - `sig_out`←`SEED`, `sample_cnt`←0.
  - Always → RUN, whatever `start`, `abort` or `resp_valid` are doing. Samples presented during SEED are dropped.
- RUN, on each cycle with `resp_valid`=1:
  - `sig_out` ← ({sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? `POLY` : 0)) ^ zero-extended `resp_in`.
  - `sample_cnt`++.
  - With `resp_valid`=0, `sig_out` and `sample_cnt` hold.
- RUN exit on window end: the accepted sample that brings `sample_cnt` to `WINDOW` also moves the state to DONE. On that same edge, `match` ← (next signature == `golden_sig`).
- RUN exit on abort: `abort`=1 → IDLE on the next edge, and any sample that cycle is not compacted. `abort` takes priority over the window-end transition and over `resp_valid`. `sig_out` and `sample_cnt` keep their partial values; `match` stays 0.
- `start` is ignored while in SEED or RUN.
- DONE:
  - Holds `sig_out`, `sample_cnt` and `match`; `resp_valid` is ignored.
  - `start`=1 → SEED, which starts a new window and clears `done` and `match`.
  - `abort`=1 (with `start`=0) → IDLE and clears `match`.
  - If `start` and `abort` are both high, `start` wins.
- `sample_cnt` never exceeds `WINDOW` and never wraps.
- Asynchronous reset asserted mid-window returns everything to the reset values immediately. No partial signature survives.

## Timing
- `start` high on edge N → SEED after N, RUN after N+1. The first sample that can be compacted is at edge N+2.
- With `resp_valid` held high from edge N+2, DONE is entered after edge N+1+`WINDOW`. `done` and `match` are visible in the following cycle.
- `golden_sig` must be stable during the cycle of the final accepted sample. It is not sampled at any other time.
- Latency from the last sample to `done` is 1 cycle, with no combinational paths from inputs to outputs.

## Test plan
- Reset values: assert `reset`=0 mid-RUN → all outputs 0 and state IDLE immediately. After release, `busy`=0 and `done`=0.
- Single sample, `WINDOW`=1, `resp_in`=0: after `start` → `sig_out`=16'hEFDF, `done`=1. With `golden_sig`=16'hEFDF → `match`=1; with 16'hEFDE → `match`=0.
- `WINDOW`=1, `resp_in`=11'h7FF → `sig_out`=16'hE820, `sample_cnt`=1.
- Gapped valid: `WINDOW`=4, `resp_valid` toggling 1,0,1,0,… → DONE only after the 4th accepted sample. The signature must match a bench model that skips invalid cycles, and `sample_cnt`=4.
- Abort and ignored start: `abort` after 10 samples → IDLE, `sample_cnt`=10, `match`=0. `start` pulsed mid-RUN → no restart, `sample_cnt` keeps incrementing.
- Back-to-back windows: `start` in DONE → SEED the next cycle, `sig_out`=16'hFFFF, `done`=0, `match`=0. Samples arriving during SEED are not compacted.
